// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: MEM-stage data-memory port controller; issues one cache request per op, holds it until dmem_resp, extends load data.
// Ports: clk/rst_n; EX/MEM op (mem_read, mem_write, funct3, mem_addr, mem_wdata); mem_advance, flush;
// cache side dmem_read/write/address/mbe/wdata out, dmem_resp/rdata in; data_resp_dp, load_data, misalign_err, stall_cycles out.
module dmem_port_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             mem_advance,
  input  logic             flush,
  input  logic             dmem_resp,
  input  logic [31:0]      dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [31:0]      dmem_address,
  output logic [3:0]       dmem_mbe,
  output logic [31:0]      dmem_wdata,
  output logic             data_resp_dp,
  output logic [31:0]      load_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, DRAIN = 2'd3;
  logic [1:0]  state, state_n, a, cur_a, q_a;
  logic [2:0]  cur_f3, q_f3;
  logic        op, mis, idle, issue, hold, take, q_rd, q_wr;
  logic [3:0]  mbe_c, q_mbe;
  logic [31:0] wdata_c, q_addr, q_wdata, load_q, word, ext;
  assign op      = (mem_read | mem_write) & ~flush;
  assign a       = mem_addr[1:0];
  assign mis     = op & (funct3[1:0] == 2'd1 ? a[0] : funct3[1:0] == 2'd2 ? |a : 1'b0);
  assign idle    = state == IDLE;
  assign issue   = idle & op & ~mis;
  assign hold    = state == BUSY || state == DRAIN;
  assign mbe_c   = mem_read ? 4'hf : funct3[1:0] == 2'd0 ? 4'b0001 << a :
                   funct3[1:0] == 2'd1 ? 4'b0011 << a : 4'hf;
  assign wdata_c = mem_wdata << {a, 3'b000};
  // Once issued, the request comes from the captured copy so a flush or pipeline change cannot disturb it.
  assign dmem_read    = issue ? mem_read  : hold & q_rd;
  assign dmem_write   = issue ? mem_write : hold & q_wr;
  assign dmem_address = issue ? {mem_addr[31:2], 2'b00} : hold ? q_addr : 32'd0;
  assign dmem_mbe     = issue ? mbe_c : hold ? q_mbe : 4'd0;
  assign dmem_wdata   = issue ? wdata_c : hold ? q_wdata : 32'd0;
  // A response only counts for a live op, either same-cycle in IDLE or while waiting in BUSY.
  assign take         = dmem_resp & op & (issue | state == BUSY);
  assign misalign_err = idle & mis;
  assign data_resp_dp = misalign_err | take | (op & state == DONE);
  assign cur_f3 = idle ? funct3 : q_f3;
  assign cur_a  = idle ? a : q_a;
  assign word   = dmem_rdata >> {cur_a, 3'b000};
  assign ext    = cur_f3[1:0] == 2'd0 ? {{24{word[7] & ~cur_f3[2]}}, word[7:0]} :
                  cur_f3[1:0] == 2'd1 ? {{16{word[15] & ~cur_f3[2]}}, word[15:0]} : dmem_rdata;
  assign load_data = misalign_err ? 32'd0 : take ? ext : load_q;
  always_comb begin
    state_n = state == IDLE  ? (issue ? (dmem_resp ? (mem_advance ? IDLE : DONE) : BUSY) : IDLE) :
              state == BUSY  ? (dmem_resp ? (mem_advance | flush ? IDLE : DONE) : flush ? DRAIN : BUSY) :
              state == DONE  ? (mem_advance | flush ? IDLE : DONE) :
                               (dmem_resp ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      q_rd         <= 1'b0;
      q_wr         <= 1'b0;
      q_f3         <= 3'd0;
      q_a          <= 2'd0;
      q_addr       <= 32'd0;
      q_mbe        <= 4'd0;
      q_wdata      <= 32'd0;
      load_q       <= 32'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        q_rd    <= mem_read;
        q_wr    <= mem_write;
        q_f3    <= funct3;
        q_a     <= a;
        q_addr  <= {mem_addr[31:2], 2'b00};
        q_mbe   <= mbe_c;
        q_wdata <= wdata_c;
      end
      load_q <= take ? ext : misalign_err ? 32'd0 : load_q;
      if (state == BUSY && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb_dmem_port_ctrl: directed vector table plus multi-cycle sequences for dmem_port_ctrl.
module tb_dmem_port_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        mem_read = 0, mem_write = 0, mem_advance = 0, flush = 0, dmem_resp = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, dmem_rdata = 0;
  logic        dmem_read, dmem_write, data_resp_dp, misalign_err;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0]  dmem_mbe;
  logic [15:0] stall_cycles;
  logic [103:0] outs;
  int checks = 0, failures = 0, rd_cnt;
  dmem_port_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_advance(mem_advance), .flush(flush),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata),
    .data_resp_dp(data_resp_dp), .load_data(load_data), .misalign_err(misalign_err),
    .stall_cycles(stall_cycles)
  );
  assign outs = {dmem_read, dmem_write, dmem_address, dmem_mbe, dmem_wdata, data_resp_dp, load_data, misalign_err};
  always #5 clk = ~clk;
  typedef struct {
    logic rd, wr, fl, adv, resp;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdata;
    logic dr, dw;
    logic [31:0] da;
    logic [3:0] mbe;
    logic [31:0] dwd;
    logic dp;
    logic [31:0] ld;
    logic mis;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic adv, input logic resp, input logic [31:0] rdata,
                        input logic fl);
    mem_read = rd; mem_write = wr; funct3 = f3; mem_addr = addr; mem_wdata = wd;
    mem_advance = adv; dmem_resp = resp; dmem_rdata = rdata; flush = fl;
  endtask
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{1,0,0,1,1,3'd0,32'h103,0,32'h80112233, 1,0,32'h100,4'hf,0,1,32'hFFFFFF80,0};
    v[1]  = '{1,0,0,1,1,3'd4,32'h103,0,32'h80112233, 1,0,32'h100,4'hf,0,1,32'h00000080,0};
    v[2]  = '{1,0,0,1,1,3'd1,32'h102,0,32'h80112233, 1,0,32'h100,4'hf,0,1,32'hFFFF8011,0};
    v[3]  = '{1,0,0,1,1,3'd5,32'h102,0,32'h80112233, 1,0,32'h100,4'hf,0,1,32'h00008011,0};
    v[4]  = '{1,0,0,1,1,3'd2,32'h104,0,32'hCAFEF00D, 1,0,32'h104,4'hf,0,1,32'hCAFEF00D,0};
    v[5]  = '{0,1,0,1,1,3'd1,32'h202,32'h0000ABCD,0, 0,1,32'h200,4'b1100,32'hABCD0000,1,0,0};
    v[6]  = '{0,1,0,1,1,3'd0,32'h301,32'h000000AA,0, 0,1,32'h300,4'b0010,32'h0000AA00,1,0,0};
    v[7]  = '{0,1,0,1,1,3'd2,32'h400,32'h12345678,0, 0,1,32'h400,4'hf,32'h12345678,1,0,0};
    v[8]  = '{1,0,0,1,1,3'd0,32'h102,0,32'h00FF0000, 1,0,32'h100,4'hf,0,1,32'hFFFFFFFF,0};
    v[9]  = '{1,0,1,1,0,3'd2,32'h500,0,0, 0,0,0,4'h0,0,0,32'hFFFFFFFF,0};
    v[10] = '{0,0,0,1,0,3'd2,32'h500,0,0, 0,0,0,4'h0,0,0,32'hFFFFFFFF,0};
    v[11] = '{1,0,0,1,0,3'd2,32'h101,0,0, 0,0,0,4'h0,0,1,0,1};
    v[12] = '{0,1,0,1,0,3'd1,32'h203,32'h1234,0, 0,0,0,4'h0,0,1,0,1};
    v[13] = '{0,0,0,1,0,3'd0,0,0,0, 0,0,0,4'h0,0,0,0,0};
    #12;
    chk("reset_outs", outs, 104'd0);
    chk("reset_stall", stall_cycles, 0);
    rst_n = 1;
    next();
    for (int i = 0; i < 14; i++) begin
      set_op(v[i].rd, v[i].wr, v[i].f3, v[i].addr, v[i].wd, v[i].adv, v[i].resp, v[i].rdata, v[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs,
          {v[i].dr, v[i].dw, v[i].da, v[i].mbe, v[i].dwd, v[i].dp, v[i].ld, v[i].mis});
      next();
    end
    chk("no_stall_yet", stall_cycles, 0);
    // LW 0x100, response three cycles after issue
    for (int c = 0; c < 4; c++) begin
      set_op(1, 0, 3'd2, 32'h100, 0, c == 3, c == 3, c == 3 ? 32'hDEADBEEF : 32'h0, 0);
      @(negedge clk);
      chk($sformatf("lw_wait%0d_req", c), {dmem_read, dmem_address}, {1'b1, 32'h100});
      chk($sformatf("lw_wait%0d_dp", c), data_resp_dp, c == 3);
      if (c == 3) chk("lw_ld", load_data, 32'hDEADBEEF);
      next();
    end
    set_op(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lw_stall", stall_cycles, 3);
    chk("lw_ld_held", {dmem_read, load_data}, {1'b0, 32'hDEADBEEF});
    next();
    // Response without mem_advance: DONE holds, no re-issue, stray resp ignored
    rd_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      set_op(1, 0, 3'd2, 32'h108, 0, c == 6, c == 1 || c == 4,
             c == 1 ? 32'h11223344 : c == 4 ? 32'hFFFF0000 : 32'h0, 0);
      @(negedge clk);
      rd_cnt += dmem_read;
      if (c >= 1) chk($sformatf("done%0d", c), {data_resp_dp, load_data}, {1'b1, 32'h11223344});
      if (c >= 2) chk($sformatf("done%0d_noreq", c), dmem_read, 0);
      next();
    end
    chk("done_one_train", rd_cnt, 2);
    chk("done_stall", stall_cycles, 4);
    // Flush while BUSY drains the outstanding read without reporting it
    for (int c = 0; c < 5; c++) begin
      set_op(c == 0 || c == 1 || c == 4, 0, 3'd2, c == 4 ? 32'h110 : 32'h10C, 0, 1, c >= 3,
             c == 3 ? 32'h55555555 : 32'h77, c == 1);
      @(negedge clk);
      if (c < 4) chk($sformatf("drain%0d", c), {dmem_read, dmem_address, data_resp_dp}, {1'b1, 32'h10C, 1'b0});
      if (c == 3) chk("drain_discard", load_data, 32'h11223344);
      if (c == 4) chk("after_drain", {dmem_read, dmem_address, data_resp_dp, load_data}, {1'b1, 32'h110, 1'b1, 32'h77});
      next();
    end
    chk("drain_stall", stall_cycles, 5);
    // Asynchronous reset in the middle of a transaction
    set_op(1, 0, 3'd2, 32'h120, 0, 0, 0, 0, 0);
    next();
    next();
    #2 rst_n = 0;
    #1;
    set_op(0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("arst_outs", outs, 104'd0);
    chk("arst_stall", stall_cycles, 0);
    next();
    rst_n = 1;
    dmem_resp = 1;
    dmem_rdata = 32'hABABABAB;
    @(negedge clk);
    chk("arst_idle_resp", outs, 104'd0);
    next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
